alu_exec: RTL and testbench
===========================

# alu_exec

Two-stage pipelined execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and returns the arithmetic/logic result, a zero flag and a branch-taken flag. It sits in the execute stage between the decode/control logic and memory/writeback. Valid/ready handshakes on both sides allow stalls, and a flush input kills in-flight work on a redirect.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill all in-flight operations, including any input accepted this cycle
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation this cycle
- in_ctrl  in  4  ALU control code
- in_a  in  WIDTH  operand A (rs1)
- in_b  in  WIDTH  operand B (rs2 or immediate)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_result  out  WIDTH  result (0 for branch and illegal codes)
- out_zero  out  1  out_result == 0
- out_taken  out  1  branch condition true (branch codes only, else 0)
- out_illegal  out  1  in_ctrl was not a defined code

## Operation
- Codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1000 BEQ (a==b); 1001 BNE (a!=b); 1010 BLT (signed a<b); 1011 BGE (signed a>=b); 1100 BLTU (unsigned a<b); 1101 BGEU (unsigned a>=b). All other codes are illegal: result 0, taken 0, illegal 1, zero 1.
- ADD/SUB are modulo 2^WIDTH; carry/overflow are discarded.
- Branch codes: out_result = 0, out_zero = 1, out_taken = compare outcome.
- Stage 1 (S1) captures ctrl, a and b on an input transfer (in_valid && in_ready). Stage 2 (S2) holds the computed result, flags and out_valid.
- s2_free = !s2_valid || out_ready. S1 advances into S2 when s1_valid && s2_free.
- in_ready = !s1_valid || s2_free. It is combinational, independent of in_valid, and never depends on flush.
- Operations leave in acceptance order. No reordering and no drops, except by flush.
- While out_valid && !out_ready, all out_* signals are held stable.
- flush = 1 at an edge clears s1_valid and s2_valid. An input transfer in the same cycle is discarded. An output transfer in the same cycle (out_valid && out_ready) still counts as delivered.

## Timing
- Reset (rst_n low, asynchronous): s1_valid = s2_valid = 0, out_valid = 0, out_result = 0, out_zero = 0, out_taken = 0, out_illegal = 0. in_ready = 1 as soon as reset deasserts.
- Latency: an operation accepted at edge N presents out_valid after edge N+1, provided S2 was free.
- Throughput: 1 operation per cycle with out_ready held high.
- Backpressure with out_ready low: S2 holds, S1 fills on the next transfer, then in_ready = 0. At most 2 operations are buffered.
- If out_ready rises while both stages are full, S2 takes S1 and S1 can accept new input in the same cycle.
- Reset asserted mid-operation discards all buffered operations with no output transfer.

## Structure
- Shared package (alu_pkg): the 4-bit code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_BEQ … ALU_BGEU) and a WIDTH default. The ALU control decoder and this unit must both take their codes from alu_pkg.
- One combinational sub-module, alu_core: (ctrl, a, b) -> (result, zero, taken, illegal). alu_exec wraps alu_core with the S1/S2 registers and the handshake logic.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, zero 1, taken 0, illegal 0, out_valid 2 edges after acceptance.
- SUB 5 − 7 -> 0xFFFFFFFE, zero 0. AND 0xF0F0 & 0x0FF0 -> 0x00F0. OR 0xF000 | 0x000F -> 0xF00F.
- a = 0xFFFFFFFF, b = 1: BLT -> taken 1, BLTU -> taken 0, BGE -> 0, BGEU -> 1. BEQ 7,7 -> 1; BNE 7,7 -> 0. All six with result 0 and zero 1.
- Backpressure:
  - Stimulus: hold out_ready = 0, offer ADD 1+1, 2+2, 3+3 back-to-back.
  - Response: 2 are accepted, then in_ready = 0 and out_result stays 2 stable.
  - Stimulus: raise out_ready.
  - Response: 2, 4, 6 are delivered on consecutive cycles.
- Flush: S1 and S2 full plus a new input offered, flush = 1 for one cycle -> next cycle out_valid = 0, in_ready = 1, and none of the three results ever appears.
- Illegal code 0011 -> illegal 1, result 0, zero 1. Then assert rst_n = 0 with 2 operations buffered -> all outputs 0 immediately, and after release no stale result is delivered.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared by the ALU control decoder and the
// execute unit, plus the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND  = 4'b0000;
  localparam alu_ctrl_t ALU_OR   = 4'b0001;
  localparam alu_ctrl_t ALU_ADD  = 4'b0010;
  localparam alu_ctrl_t ALU_SUB  = 4'b0110;
  localparam alu_ctrl_t ALU_BEQ  = 4'b1000;
  localparam alu_ctrl_t ALU_BNE  = 4'b1001;
  localparam alu_ctrl_t ALU_BLT  = 4'b1010;
  localparam alu_ctrl_t ALU_BGE  = 4'b1011;
  localparam alu_ctrl_t ALU_BLTU = 4'b1100;
  localparam alu_ctrl_t ALU_BGEU = 4'b1101;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU. Branch codes produce a zero result and
// drive taken; undefined codes produce a zero result and raise illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_ctrl_t        ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             taken_o,
  output logic             illegal_o
);

  // Decode the control code into result, branch outcome and illegal flag.
  always_comb begin
    result_o  = {WIDTH{1'b0}};
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (ctrl_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_BEQ:  taken_o  = (a_i == b_i);
      ALU_BNE:  taken_o  = (a_i != b_i);
      ALU_BLT:  taken_o  = ($signed(a_i) <  $signed(b_i));
      ALU_BGE:  taken_o  = ($signed(a_i) >= $signed(b_i));
      ALU_BLTU: taken_o  = (a_i <  b_i);
      ALU_BGEU: taken_o  = (a_i >= b_i);
      default:  illegal_o = 1'b1;
    endcase
  end

  // Zero flag follows the final result, so branches and illegal codes read 1.
  always_comb begin
    zero_o = (result_o == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: two-stage execute unit. S1 registers the operation, alu_core
// evaluates it, and S2 registers the result and flags toward the consumer.
// Valid/ready on both sides; flush empties both stages.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_taken,
  output logic             out_illegal
);

  logic             s1_valid_q, s1_valid_d;
  alu_ctrl_t        s1_ctrl_q,  s1_ctrl_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;

  logic             s2_valid_q,   s2_valid_d;
  logic [WIDTH-1:0] s2_result_q,  s2_result_d;
  logic             s2_zero_q,    s2_zero_d;
  logic             s2_taken_q,   s2_taken_d;
  logic             s2_illegal_q, s2_illegal_d;

  logic             s2_free;
  logic             s1_advance;
  logic             in_fire;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_taken;
  logic             core_illegal;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ctrl_i    (s1_ctrl_q),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .result_o  (core_result),
    .zero_o    (core_zero),
    .taken_o   (core_taken),
    .illegal_o (core_illegal)
  );

  // Handshake: S2 frees up when empty or drained; flush never gates in_ready.
  always_comb begin
    s2_free    = !s2_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_free;
    in_ready   = !s1_valid_q || s2_free;
    in_fire    = in_valid && in_ready;
  end

  // Stage 1 next state: capture on input transfer, empty on advance or flush.
  always_comb begin
    s1_ctrl_d = s1_ctrl_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_fire) begin
      s1_ctrl_d = in_ctrl;
      s1_a_d    = in_a;
      s1_b_d    = in_b;
    end else begin
      s1_ctrl_d = s1_ctrl_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
    end
  end

  // Stage 2 next state: load from S1 when it advances, otherwise hold so the
  // outputs stay stable under backpressure.
  always_comb begin
    s2_result_d  = s2_result_q;
    s2_zero_d    = s2_zero_q;
    s2_taken_d   = s2_taken_q;
    s2_illegal_d = s2_illegal_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_advance) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s1_advance && !flush) begin
      s2_result_d  = core_result;
      s2_zero_d    = core_zero;
      s2_taken_d   = core_taken;
      s2_illegal_d = core_illegal;
    end else begin
      s2_result_d  = s2_result_q;
      s2_zero_d    = s2_zero_q;
      s2_taken_d   = s2_taken_q;
      s2_illegal_d = s2_illegal_q;
    end
  end

  // Pipeline registers with asynchronous reset to an empty, all-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_ctrl_q    <= 4'b0000;
      s1_a_q       <= {WIDTH{1'b0}};
      s1_b_q       <= {WIDTH{1'b0}};
      s2_valid_q   <= 1'b0;
      s2_result_q  <= {WIDTH{1'b0}};
      s2_zero_q    <= 1'b0;
      s2_taken_q   <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_ctrl_q    <= s1_ctrl_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_zero_q    <= s2_zero_d;
      s2_taken_q   <= s2_taken_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  // Outputs come straight from the S2 registers.
  always_comb begin
    out_valid   = s2_valid_q;
    out_result  = s2_result_q;
    out_zero    = s2_zero_q;
    out_taken   = s2_taken_q;
    out_illegal = s2_illegal_q;
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vector table, hand-written backpressure/flush/reset
// sequences, then random traffic checked against a queue-based reference.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_ctrl = 4'b0000;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_taken;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_taken(out_taken), .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written straight from the opcode table.
  task automatic ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic tk, output logic ill);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 32'd0; tk = 1'b0; ill = 1'b0;
    case (c)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd6:  res = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      4'd8:  tk = (a == b);
      4'd9:  tk = (a != b);
      4'd10: tk = (sa < sb);
      4'd11: tk = (sa >= sb);
      4'd12: tk = (64'(a) < 64'(b));
      4'd13: tk = (64'(a) >= 64'(b));
      default: ill = 1'b1;
    endcase
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b, res;
    logic        zero, taken, ill;
  } vec_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    int          acc_edge;
  } op_t;

  vec_t vecs[12];
  op_t  q[$];
  int   edge_n = 0;

  task automatic offer(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b;
  endtask

  initial begin
    logic [31:0] r;
    logic tk, il, exp_rdy, exp_ov;
    op_t op;

    vecs[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{4'b1000, 32'd7,        32'd7,        32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'b1001, 32'd7,        32'd7,        32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0011, 32'd9,        32'd4,        32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{4'b1111, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1'b1};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {29'd0, out_zero, out_taken, out_illegal}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table, one at a time with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      offer(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat_valid", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_flags", i), {29'd0, out_zero, out_taken, out_illegal},
          {29'd0, vecs[i].zero, vecs[i].taken, vecs[i].ill});
    end
    @(negedge clk); @(negedge clk);

    // Backpressure: 1+1, 2+2, 3+3 with out_ready low
    out_ready = 1'b0;
    offer(4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    offer(4'b0010, 32'd2, 32'd2);
    @(negedge clk);
    offer(4'b0010, 32'd3, 32'd3);
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_result", out_result, 32'd2);
    @(negedge clk);
    chk("bp_in_ready_low2", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_result2", out_result, 32'd2);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_d2_valid", 32'(out_valid), 32'd1);
    chk("bp_d2_result", out_result, 32'd4);
    @(posedge clk); #1;
    chk("bp_d3_valid", 32'(out_valid), 32'd1);
    chk("bp_d3_result", out_result, 32'd6);
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush with both stages full and a new input offered
    @(negedge clk);
    out_ready = 1'b0;
    offer(4'b0010, 32'd10, 32'd1);
    @(negedge clk);
    offer(4'b0010, 32'd20, 32'd1);
    @(negedge clk);
    offer(4'b0010, 32'd30, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("fl_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset with two operations buffered
    out_ready = 1'b0;
    offer(4'b0011, 32'd1, 32'd2);
    @(negedge clk);
    offer(4'b0010, 32'd40, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_pre_valid", 32'(out_valid), 32'd1);
    chk("rs_pre_illegal", 32'(out_illegal), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_result", out_result, 32'd0);
    chk("rs_flags", {29'd0, out_zero, out_taken, out_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rs_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // Random traffic against the in-order queue reference
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_ctrl   = 4'($urandom_range(0, 15));
      in_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      #1;
      exp_rdy = (q.size() < 2) || out_ready;
      exp_ov  = (q.size() > 0) && (q[0].acc_edge < edge_n);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && out_valid) begin
        ref_alu(q[0].ctrl, q[0].a, q[0].b, r, tk, il);
        chk("rnd_result", out_result, r);
        chk("rnd_flags", {29'd0, out_zero, out_taken, out_illegal},
            {29'd0, (r == 32'd0), tk, il});
      end
      @(posedge clk);
      edge_n++;
      if (exp_ov && out_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else if (in_valid && exp_rdy) begin
        op.ctrl = in_ctrl; op.a = in_a; op.b = in_b; op.acc_edge = edge_n;
        q.push_back(op);
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
